// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between core load/store and host loader.
// Optional macro ARB_HOST_LOCK_EN adds host_lock, which masks core requests while high.
module ram_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ack,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
`ifdef ARB_HOST_LOCK_EN
  input  logic              host_lock,
`endif
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              owner,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t              state_q, state_d;
  logic                owner_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                ram_en_d, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_d, core_rdata_d, host_rdata_d;
  logic                core_v, grant_host;

`ifdef ARB_HOST_LOCK_EN
  assign core_v = core_req & ~host_lock;
`else
  assign core_v = core_req;
`endif

  always_comb begin
    state_d      = state_q;
    owner_d      = owner;
    cnt_d        = cnt_q;
    ram_en_d     = ram_en;
    ram_we_d     = ram_we;
    ram_addr_d   = ram_addr;
    ram_wdata_d  = ram_wdata;
    core_rdata_d = core_rdata;
    host_rdata_d = host_rdata;
    grant_host   = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_v || host_req) begin
          // on conflict the side that did not win last time gets the port
          grant_host  = (core_v && host_req) ? ~owner : host_req;
          owner_d     = grant_host;
          ram_we_d    = grant_host ? host_we    : core_we;
          ram_addr_d  = grant_host ? host_addr  : core_addr;
          ram_wdata_d = grant_host ? host_wdata : core_wdata;
          ram_en_d    = 1'b1;
          cnt_d       = WAIT_INIT;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (owner) host_rdata_d = ram_rdata;
          else       core_rdata_d = ram_rdata;
          ram_en_d = 1'b0;
          ram_we_d = 1'b0;
          state_d  = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      owner      <= 1'b1;
      cnt_q      <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      core_rdata <= '0;
      host_rdata <= '0;
    end else begin
      state_q    <= state_d;
      owner      <= owner_d;
      cnt_q      <= cnt_d;
      ram_en     <= ram_en_d;
      ram_we     <= ram_we_d;
      ram_addr   <= ram_addr_d;
      ram_wdata  <= ram_wdata_d;
      core_rdata <= core_rdata_d;
      host_rdata <= host_rdata_d;
    end
  end

  assign core_ack = (state_q == RESP) && !owner;
  assign host_ack = (state_q == RESP) &&  owner;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: main instance (WAIT_CYCLES=1) with a RAM model,
// plus WAIT_CYCLES=0/3 instances for latency checks; lock test under ARB_HOST_LOCK_EN.
module tb_ram_port_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       core_req = 1'b0, core_we = 1'b0, host_req = 1'b0, host_we = 1'b0;
  logic [7:0] core_addr = '0, core_wdata = '0, host_addr = '0, host_wdata = '0;
  logic       core_ack, host_ack, ram_en, ram_we, owner, busy;
  logic [7:0] core_rdata, host_rdata, ram_addr, ram_wdata, ram_rdata;
  logic [7:0] mem [256];
`ifdef ARB_HOST_LOCK_EN
  logic       host_lock = 1'b0;
`endif

  logic       a0_req = 1'b0, a3_req = 1'b0;
  logic       a0_ack, a0_hack, a0_en, a0_we, a0_owner, a0_busy;
  logic       a3_ack, a3_hack, a3_en, a3_we, a3_owner, a3_busy;
  logic [7:0] a0_rdata, a0_hrdata, a0_addr, a0_wdata, a0_ram_rdata;
  logic [7:0] a3_rdata, a3_hrdata, a3_addr, a3_wdata, a3_ram_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.WAIT_CYCLES(1), .ADDR_W(8), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
`ifdef ARB_HOST_LOCK_EN
    .host_lock(host_lock),
`endif
    .host_ack(host_ack), .host_rdata(host_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .owner(owner), .busy(busy)
  );

  ram_port_arbiter #(.WAIT_CYCLES(0), .ADDR_W(8), .DATA_W(8)) dut_w0 (
    .clk(clk), .rst(rst),
    .core_req(a0_req), .core_we(1'b0), .core_addr(8'h44), .core_wdata(8'h00),
    .core_ack(a0_ack), .core_rdata(a0_rdata),
    .host_req(1'b0), .host_we(1'b0), .host_addr(8'h00), .host_wdata(8'h00),
`ifdef ARB_HOST_LOCK_EN
    .host_lock(1'b0),
`endif
    .host_ack(a0_hack), .host_rdata(a0_hrdata),
    .ram_en(a0_en), .ram_we(a0_we), .ram_addr(a0_addr), .ram_wdata(a0_wdata),
    .ram_rdata(a0_ram_rdata), .owner(a0_owner), .busy(a0_busy)
  );

  ram_port_arbiter #(.WAIT_CYCLES(3), .ADDR_W(8), .DATA_W(8)) dut_w3 (
    .clk(clk), .rst(rst),
    .core_req(a3_req), .core_we(1'b0), .core_addr(8'h44), .core_wdata(8'h00),
    .core_ack(a3_ack), .core_rdata(a3_rdata),
    .host_req(1'b0), .host_we(1'b0), .host_addr(8'h00), .host_wdata(8'h00),
`ifdef ARB_HOST_LOCK_EN
    .host_lock(1'b0),
`endif
    .host_ack(a3_hack), .host_rdata(a3_hrdata),
    .ram_en(a3_en), .ram_we(a3_we), .ram_addr(a3_addr), .ram_wdata(a3_wdata),
    .ram_rdata(a3_ram_rdata), .owner(a3_owner), .busy(a3_busy)
  );

  // main RAM model; the auxiliary instances see a fixed address-derived pattern
  assign ram_rdata    = mem[ram_addr];
  assign a0_ram_rdata = a0_addr ^ 8'h5A;
  assign a3_ram_rdata = a3_addr ^ 8'h5A;

  always @(posedge clk) if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h10] = 8'hA5;
    mem[8'h01] = 8'h11;
    mem[8'h02] = 8'h22;
    mem[8'h30] = 8'h77;
    do_reset();

    // reset state
    chk1("rst_en", ram_en, 1'b0);       chk1("rst_we", ram_we, 1'b0);
    chk8("rst_addr", ram_addr, 8'h00);  chk8("rst_wdata", ram_wdata, 8'h00);
    chk8("rst_crd", core_rdata, 8'h00); chk8("rst_hrd", host_rdata, 8'h00);
    chk1("rst_cack", core_ack, 1'b0);   chk1("rst_hack", host_ack, 1'b0);
    chk1("rst_busy", busy, 1'b0);       chk1("rst_owner", owner, 1'b1);

    // core read of 0x10, WAIT_CYCLES=1
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h10;
    tick();
    chk1("t1_en_c1", ram_en, 1'b1); chk8("t1_addr", ram_addr, 8'h10);
    chk1("t1_busy", busy, 1'b1);    chk1("t1_owner", owner, 1'b0);
    tick();
    chk1("t1_en_c2", ram_en, 1'b1); chk1("t1_cack_c2", core_ack, 1'b0);
    tick();
    chk1("t1_cack", core_ack, 1'b1); chk8("t1_crd", core_rdata, 8'hA5);
    chk1("t1_hack", host_ack, 1'b0); chk1("t1_en_c3", ram_en, 1'b0);
    core_req = 1'b0;
    tick();
    chk1("t1_cack_c4", core_ack, 1'b0); chk1("t1_idle", busy, 1'b0);

    // host write 0x3C to 0x20, then core read-back
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h3C;
    tick();
    chk1("t2_we_c1", ram_we, 1'b1); chk8("t2_wdata", ram_wdata, 8'h3C);
    chk1("t2_owner", owner, 1'b1);
    tick();
    chk1("t2_we_c2", ram_we, 1'b1);
    tick();
    chk1("t2_hack", host_ack, 1'b1); chk1("t2_cack", core_ack, 1'b0);
    chk1("t2_we_resp", ram_we, 1'b0); chk8("t2_mem", mem[8'h20], 8'h3C);
    host_req = 1'b0; host_we = 1'b0;
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h20;
    tick();
    chk1("t2_idle", busy, 1'b0);
    tick();
    chk1("t2_rd_en", ram_en, 1'b1); chk1("t2_rd_we", ram_we, 1'b0);
    tick();
    tick();
    chk1("t2_cack_rd", core_ack, 1'b1); chk8("t2_crd", core_rdata, 8'h3C);
    core_req = 1'b0;
    tick();

    // conflict round-robin from reset: core, host, core, host
    core_req = 1'b1; core_addr = 8'h01; host_req = 1'b1; host_addr = 8'h02;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk1($sformatf("t3_cack_%0d", k), core_ack, 1'((k % 8) == 3));
      chk1($sformatf("t3_hack_%0d", k), host_ack, 1'((k % 8) == 7));
      if ((k % 8) == 3) chk8($sformatf("t3_crd_%0d", k), core_rdata, 8'h11);
      if ((k % 8) == 7) chk8($sformatf("t3_hrd_%0d", k), host_rdata, 8'h22);
      if ((k % 4) == 1) begin
        chk1($sformatf("t3_owner_%0d", k), owner, 1'(((k - 1) / 4) % 2));
        chk8($sformatf("t3_addr_%0d", k), ram_addr, (((k - 1) / 4) % 2) != 0 ? 8'h02 : 8'h01);
      end
    end
    core_req = 1'b0; host_req = 1'b0;

    // reset during host write ACCESS before the first write edge
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'hFF;
    do_reset();
    tick();
    chk1("t4_we_pre", ram_we, 1'b1);
    rst = 1'b1;
    #1;
    chk1("t4_en", ram_en, 1'b0);         chk1("t4_we", ram_we, 1'b0);
    chk8("t4_addr", ram_addr, 8'h00);    chk8("t4_wdata", ram_wdata, 8'h00);
    chk1("t4_busy", busy, 1'b0);         chk1("t4_owner", owner, 1'b1);
    chk8("t4_crd", core_rdata, 8'h00);   chk1("t4_hack", host_ack, 1'b0);
    host_req = 1'b0; host_we = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk8("t4_mem", mem[8'h30], 8'h77);
    core_req = 1'b1; core_addr = 8'h10;
    tick();
    chk1("t4_noack_c1", host_ack, 1'b0);
    tick();
    chk1("t4_noack_c2", host_ack, 1'b0);
    tick();
    chk1("t4_cack", core_ack, 1'b1); chk8("t4_crd_after", core_rdata, 8'hA5);
    chk1("t4_hack_c3", host_ack, 1'b0);
    core_req = 1'b0;
    tick();

    // WAIT_CYCLES = 0 and 3 latency
    a0_req = 1'b1; a3_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk1($sformatf("t5_w0_en_%0d", k), a0_en, 1'(k == 1));
      chk1($sformatf("t5_w0_ack_%0d", k), a0_ack, 1'(k == 2));
      chk1($sformatf("t5_w3_en_%0d", k), a3_en, 1'(k >= 1 && k <= 4));
      chk1($sformatf("t5_w3_ack_%0d", k), a3_ack, 1'(k == 5));
      if (k == 1) begin
        chk1("t5_w0_we", a0_we, 1'b0);         chk1("t5_w3_we", a3_we, 1'b0);
        chk1("t5_w0_owner", a0_owner, 1'b0);   chk1("t5_w3_owner", a3_owner, 1'b0);
        chk8("t5_w0_wdata", a0_wdata, 8'h00);  chk8("t5_w3_wdata", a3_wdata, 8'h00);
        chk1("t5_w0_busy", a0_busy, 1'b1);     chk1("t5_w3_busy", a3_busy, 1'b1);
      end
      if (k == 2) begin
        chk8("t5_w0_rd", a0_rdata, 8'h1E);
        chk1("t5_w0_hack", a0_hack, 1'b0);
        a0_req = 1'b0;
      end
      if (k == 5) begin
        chk8("t5_w3_rd", a3_rdata, 8'h1E);
        chk1("t5_w3_hack", a3_hack, 1'b0);
        a3_req = 1'b0;
      end
    end
    chk8("t5_w0_hrd", a0_hrdata, 8'h00);
    chk8("t5_w3_hrd", a3_hrdata, 8'h00);

`ifdef ARB_HOST_LOCK_EN
    // host lock: three back-to-back host accesses, then core on release
    host_lock = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 8'h01;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h02;
    do_reset();
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk1($sformatf("t6_cack_%0d", k), core_ack, 1'(k == 15));
      chk1($sformatf("t6_hack_%0d", k), host_ack, 1'(((k % 4) == 3) && k < 12));
      if (k == 11) host_lock = 1'b0;
      if (k == 13) begin
        chk1("t6_owner", owner, 1'b0);
        chk8("t6_addr", ram_addr, 8'h01);
      end
      if (k == 15) chk8("t6_crd", core_rdata, 8'h11);
    end
    core_req = 1'b0; host_req = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
